// File: rtl/minn_sync_sequencer.sv
// Minn timing-sync sequencer: flush/prime delay lines, threshold search, peak tracking, blanking.
// Optional search timeout enabled by defining MINN_SYNC_TIMEOUT_EN.
module minn_sync_sequencer #(
  parameter int unsigned METRIC_WIDTH = 24,
  parameter int unsigned IDX_WIDTH    = 16,
  parameter int unsigned FILL_LEN     = 64,
  parameter int unsigned HOLD_LEN     = 32,
  parameter int unsigned BLANK_LEN    = 256
`ifdef MINN_SYNC_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_LEN  = 4096
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    in_valid,
  input  logic                    metric_valid,
  input  logic [METRIC_WIDTH-1:0] metric,
  input  logic [METRIC_WIDTH-1:0] threshold,
  output logic                    dl_flush,
  output logic                    dl_valid,
  output logic                    busy,
  output logic                    detect,
  output logic [IDX_WIDTH-1:0]    detect_idx,
  output logic [METRIC_WIDTH-1:0] detect_metric,
  output logic                    timeout,
  output logic [2:0]              state_o
);

  // Counters run 0..LEN-1; the terminal value is compared against LEN-1.
  localparam int unsigned FillW  = (FILL_LEN > 1) ? $clog2(FILL_LEN) : 1;
  localparam int unsigned HoldW  = (HOLD_LEN > 1) ? $clog2(HOLD_LEN) : 1;
  localparam int unsigned BlankW = (BLANK_LEN > 1) ? $clog2(BLANK_LEN) : 1;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFlush  = 3'd1,
    StFill   = 3'd2,
    StSearch = 3'd3,
    StTrack  = 3'd4,
    StBlank  = 3'd5
  } state_e;

  state_e                  state_q, state_d;
  logic [FillW-1:0]        fill_cnt_q, fill_cnt_d;
  logic [HoldW-1:0]        hold_cnt_q, hold_cnt_d;
  logic [BlankW-1:0]       blank_cnt_q, blank_cnt_d;
  logic [IDX_WIDTH-1:0]    metric_idx_q, metric_idx_d;
  logic [METRIC_WIDTH-1:0] peak_q, peak_d;
  logic [IDX_WIDTH-1:0]    peak_idx_q, peak_idx_d;
  logic                    detect_q, detect_d;
  logic [IDX_WIDTH-1:0]    detect_idx_q, detect_idx_d;
  logic [METRIC_WIDTH-1:0] detect_metric_q, detect_metric_d;
  logic                    dl_flush_q, dl_flush_d;
  logic                    timeout_d;

`ifdef MINN_SYNC_TIMEOUT_EN
  localparam int unsigned ToW = (TIMEOUT_LEN > 1) ? $clog2(TIMEOUT_LEN) : 1;
  logic [ToW-1:0] to_cnt_q, to_cnt_d;
  logic           timeout_q;
`endif

  always_comb begin
    state_d         = state_q;
    fill_cnt_d      = fill_cnt_q;
    hold_cnt_d      = hold_cnt_q;
    blank_cnt_d     = blank_cnt_q;
    metric_idx_d    = metric_idx_q;
    peak_d          = peak_q;
    peak_idx_d      = peak_idx_q;
    detect_d        = 1'b0;
    detect_idx_d    = detect_idx_q;
    detect_metric_d = detect_metric_q;
    timeout_d       = 1'b0;
`ifdef MINN_SYNC_TIMEOUT_EN
    // Held at zero outside SEARCH, so every entry into SEARCH starts a fresh count.
    to_cnt_d = (state_q == StSearch) ? to_cnt_q : '0;
`endif

    if (metric_valid && (state_q != StIdle) && (state_q != StFlush)) begin
      metric_idx_d = metric_idx_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (start) state_d = StFlush;
      end
      StFlush: begin
        fill_cnt_d   = '0;
        metric_idx_d = '0;
        state_d      = StFill;
      end
      StFill: begin
        if (in_valid) begin
          if (fill_cnt_q == FillW'(FILL_LEN - 1)) state_d = StSearch;
          else fill_cnt_d = fill_cnt_q + 1'b1;
        end
      end
      StSearch: begin
        if (metric_valid) begin
          if (metric > threshold) begin
            state_d    = StTrack;
            peak_d     = metric;
            peak_idx_d = metric_idx_q;
            hold_cnt_d = '0;
          end
`ifdef MINN_SYNC_TIMEOUT_EN
          else if (to_cnt_q == ToW'(TIMEOUT_LEN - 1)) begin
            timeout_d = 1'b1;
            state_d   = StFlush;
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
`endif
        end
      end
      StTrack: begin
        if (metric_valid) begin
          // Strict compare: an equal later sample leaves the earliest maximum in place.
          if (metric > peak_q) begin
            peak_d     = metric;
            peak_idx_d = metric_idx_q;
            hold_cnt_d = '0;
          end else if (hold_cnt_q == HoldW'(HOLD_LEN - 1)) begin
            detect_d        = 1'b1;
            detect_idx_d    = peak_idx_q;
            detect_metric_d = peak_q;
            blank_cnt_d     = '0;
            state_d         = StBlank;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
      end
      StBlank: begin
        if (BLANK_LEN == 0) begin
          state_d = StSearch;
        end else if (metric_valid) begin
          if (blank_cnt_q == BlankW'(BLANK_LEN - 1)) state_d = StSearch;
          else blank_cnt_d = blank_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (abort) begin
      state_d         = StIdle;
      detect_d        = 1'b0;
      detect_idx_d    = detect_idx_q;
      detect_metric_d = detect_metric_q;
      timeout_d       = 1'b0;
    end

    dl_flush_d = (state_d == StFlush);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      fill_cnt_q      <= '0;
      hold_cnt_q      <= '0;
      blank_cnt_q     <= '0;
      metric_idx_q    <= '0;
      peak_q          <= '0;
      peak_idx_q      <= '0;
      detect_q        <= 1'b0;
      detect_idx_q    <= '0;
      detect_metric_q <= '0;
      dl_flush_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      fill_cnt_q      <= fill_cnt_d;
      hold_cnt_q      <= hold_cnt_d;
      blank_cnt_q     <= blank_cnt_d;
      metric_idx_q    <= metric_idx_d;
      peak_q          <= peak_d;
      peak_idx_q      <= peak_idx_d;
      detect_q        <= detect_d;
      detect_idx_q    <= detect_idx_d;
      detect_metric_q <= detect_metric_d;
      dl_flush_q      <= dl_flush_d;
    end
  end

`ifdef MINN_SYNC_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = timeout_d & 1'b0;
`endif

  assign dl_valid      = in_valid & (state_q inside {StFill, StSearch, StTrack, StBlank});
  assign busy          = (state_q != StIdle);
  assign detect        = detect_q;
  assign detect_idx    = detect_idx_q;
  assign detect_metric = detect_metric_q;
  assign dl_flush      = dl_flush_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_minn_sync_sequencer.sv
// Directed self-checking bench for minn_sync_sequencer (default parameters; TIMEOUT_LEN=16
// when MINN_SYNC_TIMEOUT_EN is defined).
module tb_minn_sync_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic        in_valid;
  logic        metric_valid;
  logic [23:0] metric;
  logic [23:0] threshold;
  logic        dl_flush;
  logic        dl_valid;
  logic        busy;
  logic        detect;
  logic [15:0] detect_idx;
  logic [23:0] detect_metric;
  logic        timeout;
  logic [2:0]  state_o;

  int n_err;
  int n_checks;
  int seen;

  minn_sync_sequencer #(
    .METRIC_WIDTH(24),
    .IDX_WIDTH   (16),
    .FILL_LEN    (64),
    .HOLD_LEN    (32),
    .BLANK_LEN   (256)
`ifdef MINN_SYNC_TIMEOUT_EN
    ,
    .TIMEOUT_LEN (16)
`endif
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .in_valid     (in_valid),
    .metric_valid (metric_valid),
    .metric       (metric),
    .threshold    (threshold),
    .dl_flush     (dl_flush),
    .dl_valid     (dl_valid),
    .busy         (busy),
    .detect       (detect),
    .detect_idx   (detect_idx),
    .detect_metric(detect_metric),
    .timeout      (timeout),
    .state_o      (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [23:0] m);
    metric_valid = 1'b1;
    metric       = m;
    tick();
    metric_valid = 1'b0;
    seen         = seen | int'(detect) | (int'(timeout) << 1);
  endtask

  // Counts dl_valid pulses while in FILL, bounded by a cycle budget.
  task automatic run_fill(input string tag);
    int cnt;
    int guard;
    cnt   = 0;
    guard = 0;
    while (state_o == 3'd2 && guard < 200) begin
      if (dl_valid) cnt++;
      guard++;
      tick();
    end
    check({tag, "_fill_cnt"}, 32'(cnt), 32'd64);
    check({tag, "_search"}, 32'(state_o), 32'd3);
  endtask

  initial begin
    n_err        = 0;
    n_checks     = 0;
    seen         = 0;
    rst          = 1'b1;
    start        = 1'b0;
    abort        = 1'b0;
    in_valid     = 1'b1;
    metric_valid = 1'b0;
    metric       = '0;
    threshold    = 24'd1000;
    repeat (3) tick();

    // Reset state
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_flush", 32'(dl_flush), 32'd0);
    check("rst_detect", 32'(detect), 32'd0);
    check("rst_idx", 32'(detect_idx), 32'd0);
    check("rst_metric", 32'(detect_metric), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("idle_dl_valid", 32'(dl_valid), 32'd0);

    // 1: start -> FLUSH for one cycle, then 64 valid samples of FILL
    rst   = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("flush_state", 32'(state_o), 32'd1);
    check("flush_pulse", 32'(dl_flush), 32'd1);
    check("flush_busy", 32'(busy), 32'd1);
    check("flush_dl_valid", 32'(dl_valid), 32'd0);
    tick();
    check("fill_state", 32'(state_o), 32'd2);
    check("flush_end", 32'(dl_flush), 32'd0);
    run_fill("t1");
    check("search_dl_valid", 32'(dl_valid), 32'd1);

    // 2: ramp 900,1100,1500 then flat 1400; peak 1500 at index 2
    send(24'd900);
    check("t2_below", 32'(state_o), 32'd3);
    send(24'd1100);
    check("t2_track", 32'(state_o), 32'd4);
    send(24'd1500);
    seen = 0;
    repeat (31) send(24'd1400);
    check("t2_no_early_detect", 32'(seen), 32'd0);
    check("t2_still_track", 32'(state_o), 32'd4);
    send(24'd1400);
    check("t2_detect", 32'(detect), 32'd1);
    check("t2_blank", 32'(state_o), 32'd5);
    check("t2_idx", 32'(detect_idx), 32'd2);
    check("t2_metric", 32'(detect_metric), 32'd1500);
    tick();
    check("t2_detect_width", 32'(detect), 32'd0);
    check("t2_idx_held", 32'(detect_idx), 32'd2);

    // 5: BLANK counts only valid samples across gaps; 255 strong samples are ignored
    seen = 0;
    for (int i = 0; i < 255; i++) begin
      send(24'd5000);
      if (i % 64 == 0) repeat (3) tick();
    end
    check("t5_blank_no_detect", 32'(seen), 32'd0);
    check("t5_blank_255", 32'(state_o), 32'd5);
    send(24'd0);
    check("t5_blank_done", 32'(state_o), 32'd3);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t5_start_ignored", 32'(state_o), 32'd3);
    check("t5_no_flush", 32'(dl_flush), 32'd0);

    // 3: equal peaks 2000 at idx 291 and 296, gapped hold samples; first peak wins
    send(24'd2000);
    check("t3_track", 32'(state_o), 32'd4);
    repeat (4) send(24'd1500);
    send(24'd2000);
    seen = 0;
    for (int i = 0; i < 26; i++) begin
      send(24'd1500);
      repeat (3) tick();
    end
    check("t3_gap_no_detect", 32'(seen), 32'd0);
    check("t3_gap_track", 32'(state_o), 32'd4);
    send(24'd1500);
    check("t3_detect", 32'(detect), 32'd1);
    check("t3_idx_first", 32'(detect_idx), 32'd291);
    check("t3_metric", 32'(detect_metric), 32'd2000);
    seen = 0;
    send(24'd2000);
    repeat (40) send(24'd1500);
    check("t3_second_blanked", 32'(seen), 32'd0);
    check("t3_in_blank", 32'(state_o), 32'd5);

    // 4: abort from BLANK, re-arm, abort on the cycle hold reaches HOLD_LEN
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_abort_idle", 32'(state_o), 32'd0);
    check("t4_abort_busy", 32'(busy), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    run_fill("t4");
    send(24'd1000);
    check("t4_equal_thr", 32'(state_o), 32'd3);
    send(24'd1200);
    check("t4_track", 32'(state_o), 32'd4);
    repeat (31) send(24'd1000);
    metric_valid = 1'b1;
    metric       = 24'd1000;
    abort        = 1'b1;
    tick();
    metric_valid = 1'b0;
    abort        = 1'b0;
    check("t4_no_detect", 32'(detect), 32'd0);
    check("t4_idle", 32'(state_o), 32'd0);
    check("t4_dl_valid", 32'(dl_valid), 32'd0);
    check("t4_idx_held", 32'(detect_idx), 32'd291);
    tick();
    check("t4_no_late_detect", 32'(detect), 32'd0);

    // 6: sub-threshold metrics in SEARCH
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    run_fill("t6");
    seen = 0;
`ifdef MINN_SYNC_TIMEOUT_EN
    repeat (15) send(24'd500);
    check("t6_no_early_timeout", 32'(seen), 32'd0);
    check("t6_still_search", 32'(state_o), 32'd3);
    send(24'd500);
    check("t6_timeout", 32'(timeout), 32'd1);
    check("t6_flush", 32'(state_o), 32'd1);
    check("t6_flush_pulse", 32'(dl_flush), 32'd1);
    check("t6_no_detect", 32'(detect), 32'd0);
    tick();
    check("t6_timeout_width", 32'(timeout), 32'd0);
    check("t6_refill", 32'(state_o), 32'd2);
    run_fill("t6r");
`else
    repeat (40) send(24'd500);
    check("t6_no_timeout", 32'(seen), 32'd0);
    check("t6_waits", 32'(state_o), 32'd3);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
